sample_player: RTL and testbench

Playback counterpart of the capture path: reads 32-bit sample words (r, g, b, 7 zero bits, hsync) from SDRAM addresses 0..last_addr and regenerates pixel_clock, RGB, hsync and vsync. Sits beside the capture checker on the same RAM port, behind the shared arbiter. The regenerated video can be looped back into the capture inputs for self-test.

---
 rtl/sample_player_pkg.sv | 21 ++
 rtl/sample_player_if.sv | 33 +++
 rtl/sample_fifo.sv | 64 ++++++
 rtl/sample_player.sv | 247 ++++++++++++++++++++++++
 tb/tb_sample_player.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_player_pkg.sv
// sample_player_pkg
// Shared definitions for the sample player: FSM state encodings and the
// bit positions of the fields inside a 32-bit sample word
// {r[7:0], g[7:0], b[7:0], 7'b0, hsync}.
package sample_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_VBLANK  = 3'd2,
        ST_PLAY    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int WORD_W    = 32;
    localparam int R_MSB     = 31;
    localparam int G_MSB     = 23;
    localparam int B_MSB     = 15;
    localparam int HSYNC_BIT = 0;

endpackage

// File: rtl/sample_player_if.sv
// sample_player_if
// RAM request/response port between the sample player (master) and the
// shared SDRAM arbiter (slave).
//   addr      RAM word address
//   rw        0 = read
//   data_in   write data (unused by a reader)
//   in_valid  request strobe
//   busy      RAM cannot accept a request this cycle
//   out_valid read data valid
//   data_out  read data
interface sample_player_if
    import sample_player_pkg::*;
#(
    parameter int ADDR_W = 23
);
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [WORD_W-1:0] data_in;
    logic              in_valid;
    logic              busy;
    logic              out_valid;
    logic [WORD_W-1:0] data_out;

    modport master (
        output addr, rw, data_in, in_valid,
        input  busy, out_valid, data_out
    );

    modport slave (
        input  addr, rw, data_in, in_valid,
        output busy, out_valid, data_out
    );
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo
// Synchronous show-ahead FIFO holding prefetched sample words.
//   clk, rst  clock, asynchronous active-high reset
//   clear_i   empty the FIFO
//   push_i    write wdata_i (ignored when full unless popping the same cycle)
//   pop_i     drop the head word (ignored when empty)
//   rdata_o   head word, valid while empty_o is low
//   count_o   number of stored words
//   empty_o   FIFO holds no words
module sample_fifo
    import sample_player_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO may accept a word only when the head leaves on the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/sample_player.sv
// sample_player
// Reads sample words 0..last_addr from SDRAM and regenerates pixel_clock,
// RGB, hsync and vsync from them.
// Optional feature macro: SAMPLE_PLAYER_LOOP_EN (honour loop_i; otherwise
// every frame ends in DONE).
//   clk, rst        clock, asynchronous active-high reset
//   start_i         level; registered rising edge starts playback
//   last_addr_i     inclusive final word address, captured on start
//   loop_i          replay the frame continuously
//   ram             RAM master port (read-only use)
//   pixel_clock_o   regenerated pixel clock
//   r_o, g_o, b_o   pixel colour
//   hsync_o         sample bit 0
//   vsync_o         high while a frame plays
//   state_o         current FSM state
//   underrun_o      sticky: FIFO empty when a pixel was due
//
// state   | meaning
// IDLE    | waiting for start edge after reset
// PREFILL | fetching words until FIFO full or frame fully fetched
// VBLANK  | vsync low for VBLANK_CYCLES, fetch continues
// PLAY    | one word per pixel period, fetch continues
// DONE    | frame finished, waiting for start edge
module sample_player
    import sample_player_pkg::*;
#(
    parameter int ADDR_W        = 23,
    parameter int CLK_DIV       = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int VBLANK_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic              loop_i,
    sample_player_if.master   ram,
    output logic              pixel_clock_o,
    output logic [7:0]        r_o,
    output logic [7:0]        g_o,
    output logic [7:0]        b_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [2:0]        state_o,
    output logic              underrun_o
);
    localparam int DW  = $clog2(CLK_DIV);
    localparam int VW  = $clog2(VBLANK_CYCLES + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, last_addr_q, last_addr_d;
    logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;
    logic              fetch_done_q, fetch_done_d, outstanding_q, outstanding_d;
    logic              last_popped_q, last_popped_d;
    logic [DW-1:0]     div_q, div_d;
    logic [VW-1:0]     vtmr_q, vtmr_d;
    logic              pix_clk_q, pix_clk_d, hsync_q, hsync_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              underrun_q, underrun_d;
    logic              start_q, start_prev_q, start_edge;
    logic              loop_en, active, issue;
    logic              fifo_clear, fifo_push, fifo_pop, fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;
    logic [FCW-1:0]    fifo_count;
    logic              unused_pad;

`ifdef SAMPLE_PLAYER_LOOP_EN
    assign loop_en = loop_i;
`else
    logic unused_loop;
    assign unused_loop = loop_i;
    assign loop_en     = 1'b0;
`endif

    // Padding bits between b and hsync carry no information.
    assign unused_pad = ^fifo_rdata[HSYNC_BIT+7:HSYNC_BIT+1];

    assign start_edge = start_q & ~start_prev_q;
    assign active     = (state_q == ST_PREFILL) || (state_q == ST_VBLANK) || (state_q == ST_PLAY);
    // Only one read in flight, so count < depth guarantees room for its data.
    assign issue      = active && !ram.busy && !outstanding_q && !fetch_done_q
                        && (fifo_count < FCW'(FIFO_DEPTH));
    assign fifo_push  = ram.out_valid && outstanding_q;

    assign ram.addr     = rd_addr_q;
    assign ram.rw       = 1'b0;
    assign ram.data_in  = '0;
    assign ram.in_valid = issue;

    assign pixel_clock_o = pix_clk_q;
    assign r_o           = r_q;
    assign g_o           = g_q;
    assign b_o           = b_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = (state_q == ST_IDLE) || (state_q == ST_PREFILL) || (state_q == ST_PLAY);
    assign state_o       = state_q;
    assign underrun_o    = underrun_q;

    sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .wdata_i (ram.data_out),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        last_addr_d   = last_addr_q;
        pop_addr_d    = pop_addr_q;
        fetch_done_d  = fetch_done_q;
        outstanding_d = outstanding_q;
        last_popped_d = last_popped_q;
        div_d         = div_q;
        vtmr_d        = vtmr_q;
        pix_clk_d     = pix_clk_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        hsync_d       = hsync_q;
        underrun_d    = underrun_q;
        fifo_clear    = 1'b0;
        fifo_pop      = 1'b0;

        if (issue) begin
            outstanding_d = 1'b1;
            // Park on the final address so an all-ones frame never wraps to 0.
            if (rd_addr_q == last_addr_q) fetch_done_d = 1'b1;
            else                          rd_addr_d    = rd_addr_q + 1'b1;
        end
        if (fifo_push) outstanding_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    last_addr_d   = last_addr_i;
                    rd_addr_d     = '0;
                    pop_addr_d    = '0;
                    fetch_done_d  = 1'b0;
                    outstanding_d = 1'b0;
                    last_popped_d = 1'b0;
                    underrun_d    = 1'b0;
                    fifo_clear    = 1'b1;
                    state_d       = ST_PREFILL;
                end
            end
            ST_PREFILL: begin
                if ((fifo_count == FCW'(FIFO_DEPTH)) || (fetch_done_q && !outstanding_q)) begin
                    vtmr_d  = VW'(VBLANK_CYCLES - 1);
                    state_d = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (vtmr_q == '0) begin
                    div_d     = '0;
                    pix_clk_d = 1'b0;
                    state_d   = ST_PLAY;
                end else begin
                    vtmr_d = vtmr_q - 1'b1;
                end
            end
            ST_PLAY: begin
                if (div_q == '0) begin
                    // Hold at d=0 with the clock low until a word is available.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        r_d        = fifo_rdata[R_MSB -: 8];
                        g_d        = fifo_rdata[G_MSB -: 8];
                        b_d        = fifo_rdata[B_MSB -: 8];
                        hsync_d    = fifo_rdata[HSYNC_BIT];
                        pix_clk_d  = 1'b1;
                        div_d      = DW'(1);
                        pop_addr_d = pop_addr_q + 1'b1;
                        if (pop_addr_q == last_addr_q) last_popped_d = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else begin
                    if (div_q == DW'(CLK_DIV / 2)) pix_clk_d = 1'b0;
                    if (div_q == DW'(CLK_DIV - 1)) begin
                        div_d = '0;
                        if (last_popped_q) begin
                            if (loop_en) begin
                                rd_addr_d     = '0;
                                pop_addr_d    = '0;
                                fetch_done_d  = 1'b0;
                                last_popped_d = 1'b0;
                                state_d       = ST_PREFILL;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q       <= 1'b0;
            start_prev_q  <= 1'b0;
            state_q       <= ST_IDLE;
            rd_addr_q     <= '0;
            last_addr_q   <= '0;
            pop_addr_q    <= '0;
            fetch_done_q  <= 1'b0;
            outstanding_q <= 1'b0;
            last_popped_q <= 1'b0;
            div_q         <= '0;
            vtmr_q        <= '0;
            pix_clk_q     <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hsync_q       <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            start_q       <= start_i;
            start_prev_q  <= start_q;
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            last_addr_q   <= last_addr_d;
            pop_addr_q    <= pop_addr_d;
            fetch_done_q  <= fetch_done_d;
            outstanding_q <= outstanding_d;
            last_popped_q <= last_popped_d;
            div_q         <= div_d;
            vtmr_q        <= vtmr_d;
            pix_clk_q     <= pix_clk_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hsync_q       <= hsync_d;
            underrun_q    <= underrun_d;
        end
    end
endmodule

// File: tb/tb_sample_player.sv
module tb_sample_player;
    import sample_player_pkg::*;

    localparam int ADDR_W        = 23;
    localparam int CLK_DIV       = 4;
    localparam int FIFO_DEPTH    = 8;
    localparam int VBLANK_CYCLES = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              loop = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              pixel_clock, hsync, vsync, underrun;
    logic [7:0]        r, g, b;
    logic [2:0]        state;

    sample_player_if #(.ADDR_W(ADDR_W)) ram_if ();

    sample_player #(
        .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .VBLANK_CYCLES(VBLANK_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .last_addr_i   (last_addr),
        .loop_i        (loop),
        .ram           (ram_if),
        .pixel_clock_o (pixel_clock),
        .r_o           (r),
        .g_o           (g),
        .b_o           (b),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .state_o       (state),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- RAM model: 1..lat_max cycle read latency ----------------
    logic [31:0]       mem [64];
    int                pend = 0;
    logic [31:0]       pend_data;
    int                lat_max = 1;
    int                proto_err = 0;
    logic [ADDR_W-1:0] req_log [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_if.out_valid <= 1'b0;
            ram_if.data_out  <= '0;
            pend             <= 0;
        end else begin
            ram_if.out_valid <= 1'b0;
            if (pend == 1) begin
                ram_if.out_valid <= 1'b1;
                ram_if.data_out  <= pend_data;
            end
            if (pend != 0) pend <= pend - 1;
            if (ram_if.in_valid) begin
                if (ram_if.busy || pend != 0 || ram_if.rw !== 1'b0 || ram_if.data_in !== '0)
                    proto_err <= proto_err + 1;
                pend      <= (lat_max > 1) ? int'($urandom_range(1, lat_max)) : 1;
                pend_data <= mem[ram_if.addr[5:0]];
                req_log.push_back(ram_if.addr);
            end
        end
    end

    int busy_mode = 0;  // 0 never, 1 random, 2 always
    initial begin
        ram_if.busy = 1'b0;
        forever begin
            @(negedge clk);
            case (busy_mode)
                0:       ram_if.busy = 1'b0;
                1:       ram_if.busy = ($urandom_range(0, 99) < 30);
                default: ram_if.busy = 1'b1;
            endcase
        end
    end

    // ---------------- video monitor ----------------
    logic [31:0] cap [$];
    int          rise_cyc [$];
    int          cyc = 0, hi_run = 0, hi_bad = 0, vl_run = 0, last_vl = 0;
    logic        pc_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (pixel_clock && !pc_prev) begin
            cap.push_back({r, g, b, 7'b0, hsync});
            rise_cyc.push_back(cyc);
        end
        if (pixel_clock) hi_run++;
        else begin
            if (pc_prev && hi_run != CLK_DIV / 2) hi_bad++;
            hi_run = 0;
        end
        if (!vsync) vl_run++;
        else begin
            if (vl_run != 0) last_vl = vl_run;
            vl_run = 0;
        end
        pc_prev = pixel_clock;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_q [$];

    task automatic build_exp(input int last, input int frames);
        exp_q.delete();
        for (int f = 0; f < frames; f++)
            for (int i = 0; i <= last; i++)
                exp_q.push_back(mem[i] & 32'hFFFF_FF01);
    endtask

    task automatic clear_mon();
        cap.delete();
        rise_cyc.delete();
        req_log.delete();
        hi_bad = 0;
    endtask

    task automatic check_stream(input string tag, input bit exact);
        if (exact) check($sformatf("%s_len", tag), cap.size(), exp_q.size());
        else       check($sformatf("%s_len", tag), cap.size() >= exp_q.size(), 1'b1);
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            check($sformatf("%s_px%0d", tag, i), cap[i], exp_q[i]);
    endtask

    task automatic check_reqs(input string tag, input int last, input int frames, input bit exact);
        int n;
        n = (last + 1) * frames;
        if (exact) check($sformatf("%s_nreq", tag), req_log.size(), n);
        else       check($sformatf("%s_nreq", tag), req_log.size() >= n, 1'b1);
        for (int k = 0; k < n && k < req_log.size(); k++)
            check($sformatf("%s_req%0d", tag, k), req_log[k], k % (last + 1));
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, st);
    endtask

    task automatic wait_caps(input int k, input int budget, input string tag);
        int n;
        n = 0;
        while (cap.size() < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, cap.size() >= k, 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mg;

        // ---- reset values ----
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", state, ST_IDLE);
        check("rst_vsync", vsync, 1'b1);
        check("rst_pclk", pixel_clock, 1'b0);
        check("rst_rgbh", {r, g, b, hsync}, 25'd0);
        check("rst_bus", {ram_if.in_valid, ram_if.rw, ram_if.data_in, ram_if.addr}, '0);
        check("rst_underrun", underrun, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- directed 4-word frame ----
        mem[0] = 32'hFF00_0001; mem[1] = 32'h00FF_0000;
        mem[2] = 32'h0000_FF01; mem[3] = 32'h1234_5600;
        last_addr = 3;
        build_exp(3, 1);
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (state !== ST_PREFILL && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("A_start_latency", n, 2);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_state(ST_DONE, 4000, "A_done");
        repeat (2) @(negedge clk);
        check_stream("A", 1'b1);
        check_reqs("A", 3, 1, 1'b1);
        for (int i = 1; i < rise_cyc.size(); i++)
            check($sformatf("A_period%0d", i), rise_cyc[i] - rise_cyc[i-1], CLK_DIV);
        check("A_high_width_bad", hi_bad, 0);
        check("A_vblank_len", last_vl, VBLANK_CYCLES);
        check("A_vsync_done", vsync, 1'b0);
        check("A_underrun", underrun, 1'b0);

        // ---- forced underrun ----
        for (int i = 0; i < 20; i++) mem[i] = $urandom();
        last_addr = 19;
        build_exp(19, 1);
        clear_mon();
        pulse_start();
        wait_caps(6, 3000, "B_reach_play");
        busy_mode = 2;
        repeat (50) @(negedge clk);
        check("B_stall_pclk", pixel_clock, 1'b0);
        check("B_stall_underrun", underrun, 1'b1);
        check("B_stall_state", state, ST_PLAY);
        busy_mode = 0;
        wait_state(ST_DONE, 3000, "B_done");
        check_stream("B", 1'b1);
        mg = 0;
        for (int i = 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - rise_cyc[i-1] > mg) mg = rise_cyc[i] - rise_cyc[i-1];
        check("B_pause_seen", mg > CLK_DIV, 1'b1);
        check("B_underrun_sticky", underrun, 1'b1);

        // ---- random busy/latency, start ignored during PLAY ----
        for (int i = 0; i < 40; i++) mem[i] = $urandom();
        last_addr = 39;
        build_exp(39, 1);
        clear_mon();
        busy_mode = 1;
        lat_max = 3;
        pulse_start();
        check("C_underrun_cleared", underrun, 1'b0);
        wait_caps(5, 4000, "C_reach_play");
        pulse_start();
        check("C_start_ignored", state, ST_PLAY);
        wait_state(ST_DONE, 8000, "C_done");
        busy_mode = 0;
        lat_max = 1;
        check_stream("C", 1'b1);
        check_reqs("C", 39, 1, 1'b1);

        // ---- asynchronous reset mid-PLAY, then replay ----
        for (int i = 0; i < 10; i++) mem[i] = $urandom();
        last_addr = 9;
        build_exp(9, 1);
        clear_mon();
        pulse_start();
        wait_caps(3, 3000, "D_reach_play");
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("D_rst_state", state, ST_IDLE);
        check("D_rst_vsync", vsync, 1'b1);
        check("D_rst_pclk", pixel_clock, 1'b0);
        check("D_rst_invalid", ram_if.in_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        pulse_start();
        wait_state(ST_DONE, 4000, "D_done");
        check_stream("D", 1'b1);
        check_reqs("D", 9, 1, 1'b1);

        // ---- single-pixel frame ----
        mem[0] = $urandom();
        last_addr = 0;
        build_exp(0, 1);
        clear_mon();
        pulse_start();
        wait_state(ST_DONE, 3000, "E_done");
        check_stream("E", 1'b1);
        check_reqs("E", 0, 1, 1'b1);

        // ---- loop input ----
        mem[0] = $urandom();
        mem[1] = $urandom();
        last_addr = 1;
        loop = 1'b1;
        clear_mon();
`ifdef SAMPLE_PLAYER_LOOP_EN
        build_exp(1, 3);
        pulse_start();
        wait_caps(6, 8000, "F_three_frames");
        loop = 1'b0;
        wait_state(ST_DONE, 3000, "F_done");
        check_stream("F", 1'b0);
        check_reqs("F", 1, 3, 1'b0);
        check("F_vblank_len", last_vl, VBLANK_CYCLES);
`else
        build_exp(1, 1);
        pulse_start();
        wait_state(ST_DONE, 3000, "F_done");
        repeat (20) @(negedge clk);
        check("F_stays_done", state, ST_DONE);
        check_stream("F", 1'b1);
        check_reqs("F", 1, 1, 1'b1);
        loop = 1'b0;
`endif

        check("protocol_errors", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
